// File: rtl/gtp_capture_pkg.sv
// Shared definitions for the GTP lane capture bank: lane FSM states,
// register offsets and CTRL/STAT field positions.
package gtp_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_K  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

    localparam int MAX_LANES = 8;

    localparam int REG_CTRL  = 0;
    localparam int REG_STAT  = 1;
    localparam int REG_WPTR0 = 2;

    localparam int CTRL_ARM_LSB  = 0;
    localparam int CTRL_RING_LSB = 8;
    localparam int CTRL_MASK_LSB = 16;

    localparam int STAT_DONE_LSB = 0;
    localparam int STAT_BUSY_LSB = 8;
    localparam int STAT_WRAP_LSB = 16;

endpackage

// File: rtl/gtp_capture_chan.sv
// One capture lane: arm/K-start FSM, write pointer and a simple dual-port
// record RAM (write port from the lane, registered read port for Wishbone).
module gtp_capture_chan
    import gtp_capture_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_wr_i,
    input  logic                  arm_wr_i,
    input  logic                  ring_i,
    input  logic                  charisk_i,
    input  logic [15:0]           dat_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [15:0]           rdata_o,
    output logic [DEPTH_LOG2-1:0] wptr_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  wrapped_o,
    output logic                  ready_o
);

    cap_state_e            state_q;
    logic [DEPTH_LOG2-1:0] wptr_q;
    logic                  done_q;
    logic                  wrapped_q;
    logic                  ready_q;
    logic                  ring_mode_q;
    logic [15:0]           rdata_q;
    logic [15:0]           mem [2**DEPTH_LOG2];

    logic disarm;
    logic store;
    logic last_slot;

    // A CTRL write in the same cycle as a data word wins: nothing is stored.
    assign disarm    = ctrl_wr_i & ~arm_wr_i;
    assign last_slot = &wptr_q;
    assign store     = (state_q == ST_CAPTURE) & ~charisk_i & ~disarm;

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wptr_q] <= dat_i;
        end
        rdata_q <= mem[raddr_i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            done_q      <= 1'b0;
            wrapped_q   <= 1'b0;
            ready_q     <= 1'b0;
            ring_mode_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ctrl_wr_i && arm_wr_i) begin
                        state_q     <= ST_WAIT_K;
                        wptr_q      <= '0;
                        done_q      <= 1'b0;
                        wrapped_q   <= 1'b0;
                        ring_mode_q <= ring_i;
                    end
                end
                ST_WAIT_K: begin
                    if (disarm) begin
                        state_q <= ST_IDLE;
                    end else if (charisk_i) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (disarm) begin
                        // Ring records end on disarm; single-shot records abort.
                        if (ring_mode_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (store) begin
                        wptr_q <= wptr_q + 1'b1;
                        if (last_slot) begin
                            wrapped_q <= 1'b1;
                            if (!ring_mode_q) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                ready_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (disarm) begin
                        state_q   <= ST_IDLE;
                        done_q    <= 1'b0;
                        wrapped_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rdata_o   = rdata_q;
    assign wptr_o    = wptr_q;
    assign busy_o    = (state_q == ST_WAIT_K) | (state_q == ST_CAPTURE);
    assign done_o    = done_q;
    assign wrapped_o = wrapped_q;
    assign ready_o   = ready_q;

endmodule

// File: rtl/gtp_capture_bank.sv
// NCH-lane GTP capture buffer with a Wishbone classic slave for control and
// record readback. Ring (pre-trigger) mode is built only with GTP_CAPTURE_RING_EN.
module gtp_capture_bank
    import gtp_capture_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DEPTH_LOG2 = 9,
    parameter int AW         = 4 + DEPTH_LOG2
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_adr,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack,
    input  logic [16*NCH-1:0] gtp_dat,
    input  logic [NCH-1:0]    gtp_charisk,
    output logic [NCH-1:0]    ready,
    output logic              irq
);

    logic                  ack_q;
    logic                  sel_mem_q;
    logic [2:0]            lane_q;
    logic [31:0]           reg_rd_q;
    logic [NCH-1:0]        arm_q;
    logic [NCH-1:0]        mask_q;

    logic                  req;
    logic                  is_mem;
    logic                  ctrl_wr;
    logic [AW-2:0]         reg_idx;
    logic [2:0]            lane_sel;
    logic [31:0]           reg_val;
    logic [15:0]           mem_word;
    logic [NCH-1:0]        ring_mode;
    logic [NCH-1:0]        ring_wr;
    logic [NCH-1:0]        done;
    logic [NCH-1:0]        busy;
    logic [NCH-1:0]        wrapped;
    logic [DEPTH_LOG2-1:0] wptr    [NCH];
    logic [15:0]           rd_data [NCH];

    // Ack is forced low for a cycle after each ack, so a held strobe is
    // served every other cycle.
    assign req      = wb_cyc & wb_stb & ~ack_q;
    assign is_mem   = wb_adr[AW-1];
    assign reg_idx  = wb_adr[AW-2:0];
    assign lane_sel = wb_adr[DEPTH_LOG2+2:DEPTH_LOG2];
    assign ctrl_wr  = req & wb_we & ~is_mem & (reg_idx == (AW-1)'(REG_CTRL));

`ifdef GTP_CAPTURE_RING_EN
    logic [NCH-1:0] ring_q;

    assign ring_wr   = wb_dat_i[CTRL_RING_LSB +: NCH];
    assign ring_mode = ring_q;

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            ring_q <= '0;
        end else if (ctrl_wr) begin
            ring_q <= ring_wr;
        end
    end
`else
    assign ring_wr   = '0;
    assign ring_mode = '0;
`endif

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            ack_q     <= 1'b0;
            sel_mem_q <= 1'b0;
            lane_q    <= '0;
            reg_rd_q  <= '0;
            arm_q     <= '0;
            mask_q    <= '0;
        end else begin
            ack_q <= req;
            if (ctrl_wr) begin
                arm_q  <= wb_dat_i[CTRL_ARM_LSB +: NCH];
                mask_q <= wb_dat_i[CTRL_MASK_LSB +: NCH];
            end
            if (req) begin
                sel_mem_q <= is_mem;
                lane_q    <= lane_sel;
                reg_rd_q  <= reg_val;
            end
        end
    end

    always_comb begin
        reg_val = '0;
        if (reg_idx == (AW-1)'(REG_CTRL)) begin
            reg_val[CTRL_ARM_LSB  +: NCH] = arm_q;
            reg_val[CTRL_RING_LSB +: NCH] = ring_mode;
            reg_val[CTRL_MASK_LSB +: NCH] = mask_q;
        end else if (reg_idx == (AW-1)'(REG_STAT)) begin
            reg_val[STAT_DONE_LSB +: NCH] = done;
            reg_val[STAT_BUSY_LSB +: NCH] = busy;
            reg_val[STAT_WRAP_LSB +: NCH] = wrapped;
        end
        for (int i = 0; i < NCH; i++) begin
            if (reg_idx == (AW-1)'(REG_WPTR0 + i)) begin
                reg_val[DEPTH_LOG2-1:0] = wptr[i];
            end
        end
    end

    // RAM outputs are already registered; lanes beyond NCH read as zero.
    always_comb begin
        mem_word = '0;
        for (int i = 0; i < NCH; i++) begin
            if (lane_q == 3'(i)) begin
                mem_word = rd_data[i];
            end
        end
    end

    assign wb_ack   = ack_q;
    assign wb_dat_o = !ack_q    ? 32'h0 :
                      sel_mem_q ? {16'h0, mem_word} : reg_rd_q;
    assign irq      = |(done & mask_q);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            gtp_capture_chan #(
                .DEPTH_LOG2 (DEPTH_LOG2)
            ) u_chan (
                .clk       (wb_clk),
                .rst_n     (wb_rst),
                .ctrl_wr_i (ctrl_wr),
                .arm_wr_i  (wb_dat_i[CTRL_ARM_LSB + gi]),
                .ring_i    (ring_wr[gi]),
                .charisk_i (gtp_charisk[gi]),
                .dat_i     (gtp_dat[16*gi +: 16]),
                .raddr_i   (wb_adr[DEPTH_LOG2-1:0]),
                .rdata_o   (rd_data[gi]),
                .wptr_o    (wptr[gi]),
                .busy_o    (busy[gi]),
                .done_o    (done[gi]),
                .wrapped_o (wrapped[gi]),
                .ready_o   (ready[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_gtp_capture_bank.sv
// Scenario bench for gtp_capture_bank (NCH=4, DEPTH_LOG2=6); expected samples
// and register values are queued when driven and popped at readback.
module tb_gtp_capture_bank;

    localparam int NCH = 4;
    localparam int DL2 = 6;
    localparam int AW  = 4 + DL2;

    logic              wb_clk;
    logic              wb_rst;
    logic              wb_cyc;
    logic              wb_stb;
    logic              wb_we;
    logic [AW-1:0]     wb_adr;
    logic [31:0]       wb_dat_i;
    logic [31:0]       wb_dat_o;
    logic              wb_ack;
    logic [16*NCH-1:0] gtp_dat;
    logic [NCH-1:0]    gtp_charisk;
    logic [NCH-1:0]    ready;
    logic              irq;

    int errors = 0;
    int checks = 0;
    int ready_cnt [NCH];
    logic [31:0] exp_q [$];

    gtp_capture_bank #(.NCH(NCH), .DEPTH_LOG2(DL2), .AW(AW)) dut (
        .wb_clk      (wb_clk),
        .wb_rst      (wb_rst),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_adr      (wb_adr),
        .wb_dat_i    (wb_dat_i),
        .wb_dat_o    (wb_dat_o),
        .wb_ack      (wb_ack),
        .gtp_dat     (gtp_dat),
        .gtp_charisk (gtp_charisk),
        .ready       (ready),
        .irq         (irq)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    initial begin
        for (int i = 0; i < NCH; i++) ready_cnt[i] = 0;
    end
    always @(negedge wb_clk) begin
        for (int i = 0; i < NCH; i++) if (ready[i] === 1'b1) ready_cnt[i]++;
    end

    function automatic logic [AW-1:0] mem_adr(input int lane, input int idx);
        mem_adr = {1'b1, lane[2:0], idx[DL2-1:0]};
    endfunction

    task automatic wb_xfer(input logic we, input logic [AW-1:0] adr,
                           input logic [31:0] wd, output logic [31:0] rd);
        int n = 0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = wd;
        @(negedge wb_clk);
        while (wb_ack !== 1'b1 && n < 20) begin
            @(negedge wb_clk);
            n++;
        end
        checks++;
        if (wb_ack !== 1'b1) begin
            errors++;
            $display("FAIL wb_ack_timeout adr=%h got ack=%b expected 1", adr, wb_ack);
        end
        rd = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        $display("wb %s adr=%h wdat=%h rdat=%h", we ? "wr" : "rd", adr, wd, rd);
    endtask

    task automatic wb_write(input logic [AW-1:0] adr, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, wd, dummy);
    endtask

    task automatic wb_read(input logic [AW-1:0] adr, output logic [31:0] rd);
        wb_xfer(1'b0, adr, 32'h0, rd);
    endtask

    task automatic drive_word(input int lane, input logic [15:0] d, input logic k);
        gtp_dat[16*lane +: 16] = d;
        gtp_charisk[lane]      = k;
        @(negedge wb_clk);
    endtask

    // Start K, then `count` samples base+i, a K before every kevery-th sample.
    task automatic stream(input int lane, input int base, input int count,
                          input int kevery, input bit push);
        drive_word(lane, 16'hBCBC, 1'b1);
        for (int i = 0; i < count; i++) begin
            if (kevery > 0 && (i % kevery) == kevery - 1)
                drive_word(lane, 16'hBC00 + 16'(i), 1'b1);
            drive_word(lane, 16'(base + i), 1'b0);
            if (push) exp_q.push_back(32'(16'(base + i)));
        end
        gtp_charisk[lane] = 1'b1;
    endtask

    task automatic read_record(input int lane, input string tag);
        logic [31:0] d, e;
        for (int i = 0; i < (1 << DL2); i++) begin
            wb_read(mem_adr(lane, i), d);
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL %s word %0d: got %h expected %h", tag, i, d, e);
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] d, e;
        checks++;
        if ({wb_ack, wb_dat_o, ready, irq} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b dat=%h ready=%b irq=%b expected all 0",
                     wb_ack, wb_dat_o, ready, irq);
        end
        @(negedge wb_clk) wb_rst = 1'b1;
        @(negedge wb_clk);
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back(32'h0);
            wb_read(AW'(r), d);
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected %h", r, d, e);
            end
        end
        // Held strobe: ack must pulse 1,0,1.
        @(negedge wb_clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = AW'(1);
        for (int c = 0; c < 3; c++) begin
            @(negedge wb_clk);
            checks++;
            if (wb_ack !== ((c == 1) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL ack_pulse cycle %0d: got %b expected %b", c, wb_ack, c != 1);
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge wb_clk);
    endtask

    task automatic test_single_shot;
        logic [31:0] d;
        int rc0 = ready_cnt[0];
        wb_write(AW'(0), 32'h0000_0001);
        wb_read(AW'(1), d);
        checks++;
        if (d !== 32'h0000_0100) begin errors++; $display("FAIL ss_busy: got %h expected 00000100", d); end
        stream(0, 0, 64, 0, 1'b1);
        checks++;
        if (ready[0] !== 1'b1) begin errors++; $display("FAIL ss_ready_rise: got %b expected 1", ready[0]); end
        @(negedge wb_clk);
        checks++;
        if (ready[0] !== 1'b0) begin errors++; $display("FAIL ss_ready_fall: got %b expected 0", ready[0]); end
        wb_read(AW'(1), d);
        checks++;
        if (d !== 32'h0001_0001) begin errors++; $display("FAIL ss_stat: got %h expected 00010001", d); end
        wb_read(AW'(2), d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL ss_wptr0: got %h expected 0", d); end
        checks++;
        if (ready_cnt[0] - rc0 !== 1) begin
            errors++; $display("FAIL ss_ready_count: got %0d expected 1", ready_cnt[0] - rc0);
        end
        read_record(0, "ss_mem");
        wb_write(AW'(0), 32'h0);
        wb_read(AW'(1), d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL ss_clear: got %h expected 0", d); end
    endtask

    task automatic test_k_interleave;
        logic [31:0] d;
        wb_write(AW'(0), 32'h0000_0001);
        stream(0, 16'h0100, 64, 8, 1'b1);
        checks++;
        if (ready[0] !== 1'b1) begin errors++; $display("FAIL k_ready: got %b expected 1", ready[0]); end
        read_record(0, "k_mem");
        wb_write(AW'(0), 32'h0);
        wb_read(AW'(1), d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL k_clear: got %h expected 0", d); end
    endtask

    task automatic test_abort;
        logic [31:0] d;
        int rc1 = ready_cnt[1];
        gtp_charisk[1] = 1'b0;
        wb_write(AW'(0), 32'h0000_0002);
        wb_read(AW'(1), d);
        checks++;
        if (d !== 32'h0000_0200) begin errors++; $display("FAIL abort_busy: got %h expected 00000200", d); end
        wb_write(AW'(0), 32'h0);
        drive_word(1, 16'hBCBC, 1'b1);
        drive_word(1, 16'h1234, 1'b0);
        wb_read(AW'(1), d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL abort_stat: got %h expected 0", d); end
        checks++;
        if (ready_cnt[1] !== rc1) begin
            errors++; $display("FAIL abort_ready: got %0d pulses expected 0", ready_cnt[1] - rc1);
        end
        gtp_charisk[1] = 1'b1;
    endtask

    task automatic test_irq;
        logic [31:0] d;
        gtp_charisk[3] = 1'b0;
        wb_write(AW'(0), 32'h0008_0009);
        stream(0, 16'h0200, 64, 0, 1'b0);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_lane0_only: got %b expected 0", irq); end
        wb_read(AW'(1), d);
        checks++;
        if (d !== 32'h0001_0801) begin errors++; $display("FAIL irq_stat_mid: got %h expected 00010801", d); end
        stream(3, 16'h0300, 64, 0, 1'b0);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_lane3_done: got %b expected 1", irq); end
        wb_read(AW'(1), d);
        checks++;
        if (d !== 32'h0009_0009) begin errors++; $display("FAIL irq_stat_end: got %h expected 00090009", d); end
        wb_read(AW'(0), d);
        checks++;
        if (d !== 32'h0008_0009) begin errors++; $display("FAIL irq_ctrl: got %h expected 00080009", d); end
        wb_write(AW'(0), 32'h0008_0000);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
        wb_read(AW'(1), d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL irq_stat_clear: got %h expected 0", d); end
    endtask

    task automatic test_reset_midcapture;
        logic [31:0] d;
        wb_write(AW'(0), 32'h0001_0001);
        stream(0, 0, 64, 0, 1'b0);
        wb_write(AW'(0), 32'h0001_0005);
        stream(2, 16'h0400, 10, 0, 1'b0);
        gtp_charisk[2] = 1'b0;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL rst_irq_before: got %b expected 1", irq); end
        #2 wb_rst = 1'b0;
        #1;
        checks++;
        if ({irq, ready, wb_ack} !== '0) begin
            errors++;
            $display("FAIL rst_async: got irq=%b ready=%b ack=%b expected 0", irq, ready, wb_ack);
        end
        @(negedge wb_clk);
        @(negedge wb_clk) wb_rst = 1'b1;
        gtp_charisk[2] = 1'b1;
        for (int r = 0; r < 3; r++) begin
            wb_read((r == 2) ? AW'(4) : AW'(r), d);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL rst_reg%0d: got %h expected 0", r, d); end
        end
    endtask

    task automatic test_ring_bits;
        logic [31:0] d, e;
`ifdef GTP_CAPTURE_RING_EN
        exp_q.push_back(32'h0000_0F00);
`else
        exp_q.push_back(32'h0);
`endif
        wb_write(AW'(0), 32'h0000_FF00);
        wb_read(AW'(0), d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL ring_bits: got %h expected %h", d, e); end
        wb_write(AW'(0), 32'h0);
    endtask

`ifdef GTP_CAPTURE_RING_EN
    task automatic test_ring;
        logic [31:0] d;
        int rc2 = ready_cnt[2];
        wb_write(AW'(0), 32'h0000_0404);
        stream(2, 0, 100, 0, 1'b0);
        wb_write(AW'(0), 32'h0000_0400);
        wb_read(AW'(4), d);
        checks++;
        if (d !== 32'd36) begin errors++; $display("FAIL ring_wptr: got %h expected 24", d); end
        wb_read(AW'(1), d);
        checks++;
        if (d !== 32'h0004_0004) begin errors++; $display("FAIL ring_stat: got %h expected 00040004", d); end
        wb_read(mem_adr(2, 36), d);
        checks++;
        if (d !== 32'd36) begin errors++; $display("FAIL ring_oldest: got %h expected 24", d); end
        wb_read(mem_adr(2, 35), d);
        checks++;
        if (d !== 32'd99) begin errors++; $display("FAIL ring_newest: got %h expected 63", d); end
        checks++;
        if (ready_cnt[2] - rc2 !== 1) begin
            errors++; $display("FAIL ring_ready: got %0d expected 1", ready_cnt[2] - rc2);
        end
        wb_write(AW'(0), 32'h0);
        wb_read(AW'(1), d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL ring_clear: got %h expected 0", d); end
    endtask
`endif

    initial begin
        wb_rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_adr = '0; wb_dat_i = '0; gtp_dat = '0; gtp_charisk = '1;
        repeat (3) @(negedge wb_clk);
        test_reset;
        test_single_shot;
        test_k_interleave;
        test_abort;
        test_irq;
        test_ring_bits;
`ifdef GTP_CAPTURE_RING_EN
        test_ring;
`endif
        test_reset_midcapture;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gtp_capture_bank.md
# gtp_capture_bank

Parametrised multi-channel capture buffer for GTP receive lanes, successor to the fixed four-instance 512-word lane buffers. Each of NCH 16-bit lanes gets an independent block-RAM record, armed over Wishbone and started on the next K-character. Single-shot and ring (pre-trigger history) modes are supported. The block sits on the Wishbone intercon next to the register and SPI slaves; lane data must already be resynchronised into wb_clk.

## Interface
- NCH, 4: lane count, 1..8
- DEPTH_LOG2, 9: record depth 2^DEPTH_LOG2 samples per lane, 6..12
- AW, 4+DEPTH_LOG2: word-address width = 1 + 3 + DEPTH_LOG2

- wb_clk  in  1  sole clock, rising edge
- wb_rst  in  1  asynchronous, active-low reset
- wb_cyc, wb_stb, wb_we  in  1 each  Wishbone classic slave strobes
- wb_adr  in  AW  word address (byte address [AW+1:2] from intercon)
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, reset 0
- wb_ack  out  1  acknowledge, reset 0
- gtp_dat  in  16*NCH  lane data, lane i at [16i+15:16i]
- gtp_charisk  in  NCH  1 = lane word is K-character (not stored)
- ready  out  NCH  one-cycle pulse when lane enters DONE, reset 0
- irq  out  1  OR of (done & irq_mask), level, reset 0

## Operation
- Address map: wb_adr[AW-1]=0 registers, =1 memory; memory word index = wb_adr[DEPTH_LOG2-1:0], lane = wb_adr[DEPTH_LOG2+2:DEPTH_LOG2].
- Reg 0 CTRL (RW): [7:0] arm, [15:8] ring mode, [23:16] irq_mask; bits for lanes >= NCH read 0.
- Reg 1 STAT (RO): [7:0] done, [15:8] busy, [23:16] wrapped.
- Reg 2+i WPTR_i (RO): next write index of lane i, zero-extended.
- Memory reads return sample in [15:0], [31:16]=0; memory writes acked, no effect; unmapped regs read 0.
- Per-lane FSM: IDLE -> (arm rises) WAIT_K -> (charisk=1) CAPTURE -> DONE.
- CAPTURE: each cycle with charisk=0 writes gtp_dat to RAM[wptr], wptr += 1 modulo 2^DEPTH_LOG2; K words skipped.
- Single-shot: after 2^DEPTH_LOG2 stores -> DONE, wptr = 0, wrapped = 1.
- Ring: wrap continues; wrapped set on first wrap; arm written 0 -> DONE; wptr marks oldest sample if wrapped.
- Arm written 0 in WAIT_K, or in CAPTURE single-shot: abort to IDLE, done=0, no ready pulse.
- Arm written 1 while busy or DONE: no effect until lane returns to IDLE; DONE -> IDLE on arm 0, clearing done/wrapped.
- Entering WAIT_K clears wptr, wrapped, done.

## Timing
- Wishbone: ack one cycle after cyc&stb, high one cycle, then low for one cycle even if stb held; read data valid with ack (registered BRAM).
- Sample presented cycle t stored at t+1; the K word that starts CAPTURE is not stored; first stored sample is the next non-K word.
- busy high from cycle after arm write to DONE; done and ready assert the cycle after the last store (single-shot) or after the CTRL write (ring).
- CTRL write and K or last store in same cycle: CTRL write takes priority.
- Reset mid-capture: all FSMs IDLE, registers 0, RAM contents retained but undefined.

## Configuration
- GTP_CAPTURE_RING_EN defined: ring mode as above.
- Undefined: CTRL[15:8] read 0 and ignored, wrapped only from single-shot completion, ring logic not synthesised.

## Structure
- Package gtp_capture_pkg: FSM state enum (IDLE, WAIT_K, CAPTURE, DONE), register offsets, CTRL/STAT field positions, lane limit 8.
- Sub-module gtp_capture_chan: one lane FSM, wptr, simple dual-port BRAM (write port lane, read port Wishbone); top instantiates NCH via generate and muxes read data by lane field.

## Test plan
- Reset, read CTRL/STAT/WPTR_0 -> all 0, wb_ack one cycle per access.
- NCH=4, DEPTH_LOG2=6: arm lane 0, K then ramp 0x0000..0x003F -> ready[0] one pulse, STAT done=0x01 wrapped=0x01, memory words 0..63 read 0..0x3F.
- K interleaved every 8th word during capture -> K words absent from memory, 64 non-K samples stored in order.
- Ring on lane 2, stream 100 samples 0..99, write arm=0 -> WPTR_2=36, wrapped set, word 36 reads 36, word 35 reads 99.
- Arm lane 1 then disarm in WAIT_K -> IDLE, no ready, done=0; drop wb_rst mid-capture -> busy 0, irq 0 immediately.
- irq_mask lane 3, complete lanes 0 and 3 -> irq high only after lane 3 done; cleared by arm=0.
